// File: rtl/fenpin_ctrl.sv
// fenpin_ctrl: run-time controller for an even clock divider.
// Owns ratio config, start/stop sequencing and glitch-free ratio changes.
module fenpin_ctrl #(
    parameter int CNT_W    = 8,
    parameter int DEF_HALF = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             cfg_err,
    input  logic             run,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] cur_half
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] counter_q, counter_d;
    logic [CNT_W-1:0] cur_half_q, cur_half_d;
    logic [CNT_W-1:0] pend_half_q, pend_half_d;
    logic             pend_valid_q, pend_valid_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             cfg_err_q, cfg_err_d;
    logic             busy_q, busy_d;

    logic accept;
    logic cfg_zero;
    logic cfg_good;
    logic boundary;
    logic stop_low;

    // Config handshake: one pending slot, ready while it is empty.
    assign cfg_ready = !pend_valid_q;
    assign accept    = cfg_valid && cfg_ready;
    assign cfg_zero  = (cfg_half == '0);
    assign cfg_good  = accept && !cfg_zero;

    // A half-period ends when the counter reaches N-1 (N is never 0).
    assign boundary  = (counter_q == (cur_half_q - CNT_W'(1)));

    // Stopping while low can leave at once without cutting a pulse.
    assign stop_low  = (state_q == S_RUN) && !run && !clk_out_q;

    // State register and all datapath flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            counter_q    <= '0;
            cur_half_q   <= CNT_W'(DEF_HALF);
            pend_half_q  <= '0;
            pend_valid_q <= 1'b0;
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            cur_half_q   <= cur_half_d;
            pend_half_q  <= pend_half_d;
            pend_valid_q <= pend_valid_d;
            clk_out_q    <= clk_out_d;
            tick_q       <= tick_d;
            cfg_err_q    <= cfg_err_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state: STOP finishes the high half before returning to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_RUN;
            end
            S_RUN: begin
                if (!run) begin
                    if (!clk_out_q)    state_d = S_IDLE;
                    else if (boundary) state_d = S_IDLE;
                    else               state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (run)           state_d = S_RUN;
                else if (boundary) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: counting, toggling and ratio updates only at safe points.
    always_comb begin
        counter_d    = counter_q;
        cur_half_d   = cur_half_q;
        pend_half_d  = pend_half_q;
        pend_valid_d = pend_valid_q;
        clk_out_d    = clk_out_q;
        tick_d       = 1'b0;
        cfg_err_d    = accept && cfg_zero;
        busy_d       = (state_d != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                counter_d = '0;
                clk_out_d = 1'b0;
                if (pend_valid_q) begin
                    cur_half_d   = pend_half_q;
                    pend_valid_d = 1'b0;
                end else if (cfg_good) begin
                    cur_half_d = cfg_half;
                end
            end
            S_RUN, S_STOP: begin
                if (stop_low) begin
                    counter_d = '0;
                    if (pend_valid_q) begin
                        cur_half_d   = pend_half_q;
                        pend_valid_d = 1'b0;
                    end
                end else if (boundary) begin
                    counter_d = '0;
                    clk_out_d = !clk_out_q;
                    tick_d    = 1'b1;
                    if (pend_valid_q) begin
                        cur_half_d   = pend_half_q;
                        pend_valid_d = 1'b0;
                    end
                end else begin
                    counter_d = counter_q + CNT_W'(1);
                end
                // Slot is empty whenever an accept happens, so no clash.
                if (cfg_good) begin
                    pend_valid_d = 1'b1;
                    pend_half_d  = cfg_half;
                end
            end
            default: begin
                counter_d = '0;
            end
        endcase
    end

    // Registered outputs.
    always_comb begin
        clk_out  = clk_out_q;
        tick     = tick_q;
        cfg_err  = cfg_err_q;
        busy     = busy_q;
        cur_half = cur_half_q;
    end

endmodule

// File: tb/tb_fenpin_ctrl.sv
// tb_fenpin_ctrl: randomized scoreboard bench for fenpin_ctrl.
// Reference model tracks edges remaining in the current half-period.
module tb_fenpin_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_valid;
    logic [W-1:0] cfg_half;
    logic         cfg_ready;
    logic         cfg_err;
    logic         run;
    logic         clk_out;
    logic         tick;
    logic         busy;
    logic [W-1:0] cur_half;

    fenpin_ctrl #(.CNT_W(W), .DEF_HALF(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_half  (cfg_half),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .run       (run),
        .clk_out   (clk_out),
        .tick      (tick),
        .busy      (busy),
        .cur_half  (cur_half)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         clk_out;
        logic         tick;
        logic         busy;
        logic         ready;
        logic         err;
        logic [W-1:0] half;
    } exp_t;

    exp_t q[$];
    exp_t e;

    int n_pass  = 0;
    int n_total = 0;

    // model: 0 idle, 1 running, 2 finishing high half before idle
    int m_mode;
    bit m_clk, m_tick, m_err, m_pv;
    int m_half, m_ph, m_rem;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic model_step(input bit r, input bit cv, input int ch, input bit rn);
        bit acc, good, bnd;
        if (r) begin
            m_mode = 0; m_clk = 0; m_tick = 0; m_err = 0;
            m_half = 10; m_pv = 0; m_ph = 0; m_rem = 0;
            return;
        end
        acc    = cv && !m_pv;
        good   = acc && (ch != 0);
        m_err  = acc && (ch == 0);
        m_tick = 0;
        if (m_mode == 0) begin
            if (m_pv) begin
                m_half = m_ph; m_pv = 0;
            end else if (good) begin
                m_half = ch;
            end
            if (rn) begin
                m_mode = 1; m_rem = m_half;
            end
        end else begin
            if (m_mode == 1 && !rn && !m_clk) begin
                m_mode = 0;
                if (m_pv) begin m_half = m_ph; m_pv = 0; end
            end else begin
                bnd = (m_rem == 1);
                if (bnd) begin
                    m_clk  = !m_clk;
                    m_tick = 1;
                    if (m_pv) begin m_half = m_ph; m_pv = 0; end
                    m_rem = m_half;
                end else begin
                    m_rem = m_rem - 1;
                end
                m_mode = rn ? 1 : (bnd ? 0 : 2);
            end
            if (good) begin m_pv = 1; m_ph = ch; end
        end
    endtask

    // One clock: model sees the same inputs the DUT samples at this edge.
    task automatic cycle();
        exp_t x;
        @(posedge clk);
        model_step(rst, cfg_valid, int'(cfg_half), run);
        x.clk_out = m_clk;
        x.tick    = m_tick;
        x.busy    = (m_mode != 0);
        x.ready   = !m_pv;
        x.err     = m_err;
        x.half    = W'(m_half);
        q.push_back(x);
        #1;
    endtask

    // Monitor: compares every registered output sample against the queue.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("clk_out",   int'(clk_out),   int'(e.clk_out));
            chk("tick",      int'(tick),      int'(e.tick));
            chk("busy",      int'(busy),      int'(e.busy));
            chk("cfg_ready", int'(cfg_ready), int'(e.ready));
            chk("cfg_err",   int'(cfg_err),   int'(e.err));
            chk("cur_half",  int'(cur_half),  int'(e.half));
        end
    end

    task automatic offer(input int h);
        cfg_valid = 1'b1;
        cfg_half  = W'(h);
        cycle();
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_half = '0; run = 1'b0;
        repeat (2) cycle();
        rst = 1'b0;

        // default ratio free-running
        run = 1'b1;
        repeat (60) cycle();
        // stop while high, then while low
        run = 1'b0;
        repeat (25) cycle();
        run = 1'b1;
        repeat (5) cycle();
        run = 1'b0;
        repeat (5) cycle();

        // divide by two
        offer(1);
        run = 1'b1;
        repeat (12) cycle();
        run = 1'b0;
        repeat (4) cycle();

        // zero config rejected in idle and while running
        offer(0);
        cycle();
        offer(10);
        run = 1'b1;
        repeat (3) cycle();
        offer(0);
        // mid-half ratio change
        repeat (2) cycle();
        offer(3);
        repeat (30) cycle();
        run = 1'b0;
        repeat (10) cycle();

        // reset while stopping with a pending config
        rst = 1'b1; cycle(); rst = 1'b0;
        run = 1'b1;
        repeat (12) cycle();
        run = 1'b0;
        offer(4);
        cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        repeat (3) cycle();

        // randomized phase
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 39) == 0) run = !run;
            cfg_valid = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 7) == 0) cfg_half = W'($urandom_range(0, 20));
            else                           cfg_half = W'($urandom_range(0, 6));
            cycle();
        end
        rst = 1'b0; cfg_valid = 1'b0;

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        chk("drain", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
